// File: rtl/tmd_branch_predictor_btb.sv
// Fully associative branch target buffer with 2-bit confidence counters,
// round-robin replacement and a registered mispredict redirect.
module tmd_branch_predictor_btb #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned NUM_ENTRY = 128,
   parameter logic [1:0]  CNT_INIT  = 2'b10
) (
   input  logic            clk_i,
   input  logic            arst_ni,
   input  logic [XLEN-1:0] pc_i,
   input  logic            resolve_valid_i,
   input  logic [XLEN-1:0] curr_addr_i,
   input  logic [XLEN-1:0] next_addr_i,
   input  logic            is_jump_i,
   output logic            hit_o,
   output logic [XLEN-1:0] next_pc_o,
   output logic            pipeline_clear_o
);

   localparam int unsigned TW = XLEN - 2;
   localparam int unsigned IW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

   if ((NUM_ENTRY < 2) || ((NUM_ENTRY & (NUM_ENTRY - 1)) != 0)) begin : g_bad_num_entry
      $error("NUM_ENTRY must be a power of 2 and at least 2");
   end

   logic                 valid_r    [NUM_ENTRY];
   logic [TW-1:0]        tag_r      [NUM_ENTRY];
   logic [TW-1:0]        target_r   [NUM_ENTRY];
   logic [1:0]           cnt_r      [NUM_ENTRY];
   logic [IW-1:0]        rr_ptr_r;
   logic                 clear_r;
   logic [TW-1:0]        redirect_r;

   logic [NUM_ENTRY-1:0] f_match_s;
   logic [NUM_ENTRY-1:0] r_match_s;
   logic [NUM_ENTRY-1:0] free_s;
   logic [IW-1:0]        f_idx_s;
   logic [IW-1:0]        r_idx_s;
   logic [IW-1:0]        alloc_idx_s;
   logic                 r_hit_s;
   logic                 table_full_s;
   logic [TW-1:0]        curr_inc_s;
   logic [TW-1:0]        pred_s;
   logic [TW-1:0]        actual_s;
   logic                 mispredict_s;
   logic                 unused_low_bits_s;

   // Lowest set index wins; later (lower) iterations overwrite higher ones.
   function automatic logic [IW-1:0] first_idx(input logic [NUM_ENTRY-1:0] vec);
      logic [IW-1:0] idx;
      idx = '0;
      for (int i = int'(NUM_ENTRY) - 1; i >= 0; i--) begin
         idx = vec[i] ? IW'(i) : idx;
      end
      return idx;
   endfunction

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'd3) ? c : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'd0) ? c : c - 2'd1;
   endfunction

   // Per-entry tag compares for both lookup ports plus the free-slot vector.
   always_comb begin
      f_match_s = '0;
      r_match_s = '0;
      free_s    = '0;
      for (int i = 0; i < int'(NUM_ENTRY); i++) begin
         f_match_s[i] = valid_r[i] && (tag_r[i] == pc_i[XLEN-1:2]);
         r_match_s[i] = valid_r[i] && (tag_r[i] == curr_addr_i[XLEN-1:2]);
         free_s[i]    = ~valid_r[i];
      end
   end

   assign f_idx_s           = first_idx(f_match_s);
   assign r_idx_s           = first_idx(r_match_s);
   assign hit_o             = |f_match_s;
   assign r_hit_s           = |r_match_s;
   assign table_full_s      = ~|free_s;
   assign alloc_idx_s       = table_full_s ? rr_ptr_r : first_idx(free_s);
   assign pipeline_clear_o  = clear_r;
   assign unused_low_bits_s = ^{pc_i[1:0], curr_addr_i[1:0], next_addr_i[1:0]};

   // Fetch-side next PC: pending redirect overrides the lookup result.
   always_comb begin
      if (clear_r) begin
         next_pc_o = {redirect_r, 2'b00};
      end else if (hit_o && cnt_r[f_idx_s][1]) begin
         next_pc_o = {target_r[f_idx_s], 2'b00};
      end else begin
         next_pc_o = {pc_i[XLEN-1:2] + TW'(1), 2'b00};
      end
   end

   // Resolve-side prediction versus actual outcome, word-granular.
   always_comb begin
      curr_inc_s   = curr_addr_i[XLEN-1:2] + TW'(1);
      pred_s       = (r_hit_s && cnt_r[r_idx_s][1]) ? target_r[r_idx_s] : curr_inc_s;
      actual_s     = is_jump_i ? next_addr_i[XLEN-1:2] : curr_inc_s;
      mispredict_s = resolve_valid_i && (pred_s != actual_s);
   end

   // Redirect register and one-cycle flush pulse.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         clear_r    <= 1'b0;
         redirect_r <= '0;
      end else begin
         clear_r    <= mispredict_s;
         redirect_r <= mispredict_s ? actual_s : redirect_r;
      end
   end

   // Table training: update on hit, allocate on taken miss.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         for (int i = 0; i < int'(NUM_ENTRY); i++) begin
            valid_r[i]  <= 1'b0;
            tag_r[i]    <= '0;
            target_r[i] <= '0;
            cnt_r[i]    <= 2'b00;
         end
         rr_ptr_r <= '0;
      end else if (resolve_valid_i) begin
         if (r_hit_s) begin
            if (is_jump_i) begin
               target_r[r_idx_s] <= next_addr_i[XLEN-1:2];
               cnt_r[r_idx_s]    <= sat_inc(cnt_r[r_idx_s]);
            end else begin
               cnt_r[r_idx_s]    <= sat_dec(cnt_r[r_idx_s]);
            end
         end else if (is_jump_i) begin
            valid_r[alloc_idx_s]  <= 1'b1;
            tag_r[alloc_idx_s]    <= curr_addr_i[XLEN-1:2];
            target_r[alloc_idx_s] <= next_addr_i[XLEN-1:2];
            cnt_r[alloc_idx_s]    <= CNT_INIT;
            // Pointer only moves when a valid entry is evicted.
            if (table_full_s) begin
               rr_ptr_r <= rr_ptr_r + IW'(1);
            end else begin
               rr_ptr_r <= rr_ptr_r;
            end
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

endmodule

// File: tb/tb_tmd_branch_predictor_btb.sv
// Self-checking bench for tmd_branch_predictor_btb: directed scenarios plus
// random traffic compared against an address-level reference model.
module tb_tmd_branch_predictor_btb;

   localparam int XLEN = 64;
   localparam int N    = 8;

   logic            clk = 1'b0;
   logic            arst_ni = 1'b0;
   logic [XLEN-1:0] pc_i = '0;
   logic            resolve_valid_i = 1'b0;
   logic [XLEN-1:0] curr_addr_i = '0;
   logic [XLEN-1:0] next_addr_i = '0;
   logic            is_jump_i = 1'b0;
   logic            hit_o;
   logic [XLEN-1:0] next_pc_o;
   logic            pipeline_clear_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tmd_branch_predictor_btb #(.XLEN(XLEN), .NUM_ENTRY(N), .CNT_INIT(2'b10)) dut (
      .clk_i           (clk),
      .arst_ni         (arst_ni),
      .pc_i            (pc_i),
      .resolve_valid_i (resolve_valid_i),
      .curr_addr_i     (curr_addr_i),
      .next_addr_i     (next_addr_i),
      .is_jump_i       (is_jump_i),
      .hit_o           (hit_o),
      .next_pc_o       (next_pc_o),
      .pipeline_clear_o(pipeline_clear_o)
   );

   // Reference model: entries hold word-aligned byte addresses.
   bit          m_valid [N];
   logic [63:0] m_tag   [N];
   logic [63:0] m_tgt   [N];
   int          m_cnt   [N];
   int          m_rr;
   bit          m_clear;
   logic [63:0] m_redir;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] inc4(input logic [63:0] a);
      return (a & ~64'h3) + 64'd4;
   endfunction

   function automatic int m_find(input logic [63:0] a);
      for (int i = 0; i < N; i++) begin
         if (m_valid[i] && m_tag[i] == (a & ~64'h3)) return i;
      end
      return -1;
   endfunction

   function automatic logic [63:0] m_predict(input logic [63:0] a);
      int k;
      k = m_find(a);
      if (k >= 0 && m_cnt[k] >= 2) return m_tgt[k];
      return inc4(a);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0;
      end
      m_rr = 0; m_clear = 1'b0; m_redir = '0;
   endtask

   task automatic model_train();
      logic [63:0] actual;
      int k, slot;
      k       = m_find(curr_addr_i);
      actual  = is_jump_i ? (next_addr_i & ~64'h3) : inc4(curr_addr_i);
      m_clear = 1'b0;
      if (resolve_valid_i) begin
         if (m_predict(curr_addr_i) != actual) begin
            m_clear = 1'b1;
            m_redir = actual;
         end
         if (k >= 0) begin
            if (is_jump_i) begin
               m_tgt[k] = actual;
               m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
            end else begin
               m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
            end
         end else if (is_jump_i) begin
            slot = -1;
            for (int i = 0; i < N; i++) if (!m_valid[i] && slot < 0) slot = i;
            if (slot < 0) begin
               slot = m_rr;
               m_rr = (m_rr + 1) % N;
            end
            m_valid[slot] = 1'b1;
            m_tag[slot]   = curr_addr_i & ~64'h3;
            m_tgt[slot]   = actual;
            m_cnt[slot]   = 2;
         end
      end
   endtask

   // One clock: compare against the model mid-cycle, then advance both.
   task automatic cycle_chk(input bit chk, input string tag, input logic eh,
                            input logic [63:0] en, input logic ec);
      int hits;
      @(negedge clk);
      check_eq("hit", hit_o, m_find(pc_i) >= 0);
      check_eq("next_pc", next_pc_o, m_clear ? m_redir : m_predict(pc_i));
      check_eq("clear", pipeline_clear_o, m_clear);
      hits = 0;
      for (int i = 0; i < N; i++) if (dut.valid_r[i] && dut.tag_r[i] == pc_i[63:2]) hits++;
      check_eq("multi_hit", hits > 1, 1'b0);
      if (chk) begin
         check_eq({tag, "_hit"}, hit_o, eh);
         check_eq({tag, "_next_pc"}, next_pc_o, en);
         check_eq({tag, "_clear"}, pipeline_clear_o, ec);
      end
      @(posedge clk);
      model_train();
      #1;
   endtask

   task automatic look(input string tag, input logic [63:0] pc, input logic eh,
                       input logic [63:0] en, input logic ec);
      pc_i = pc;
      resolve_valid_i = 1'b0;
      cycle_chk(1'b1, tag, eh, en, ec);
   endtask

   task automatic resolve(input logic [63:0] curr, input logic [63:0] nxt, input logic jmp);
      pc_i = curr; curr_addr_i = curr; next_addr_i = nxt; is_jump_i = jmp;
      resolve_valid_i = 1'b1;
      cycle_chk(1'b0, "", 1'b0, '0, 1'b0);
      resolve_valid_i = 1'b0;
   endtask

   function automatic logic [63:0] rand_addr();
      return 64'h1000 + 64'($urandom_range(0, 11)) * 64'd4 + 64'($urandom_range(0, 3));
   endfunction

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      arst_ni = 1'b1;
      @(posedge clk); #1;

      look("empty", 64'h1000, 1'b0, 64'h1004, 1'b0);
      look("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b0);

      resolve(64'h2000, 64'h3000, 1'b1);
      look("alloc_clear", 64'h2000, 1'b1, 64'h3000, 1'b1);
      look("alloc_pred", 64'h2000, 1'b1, 64'h3000, 1'b0);

      resolve(64'h2000, 64'h0, 1'b0);
      look("hyst_clear", 64'h2000, 1'b1, 64'h2004, 1'b1);
      look("hyst_weak", 64'h2000, 1'b1, 64'h2004, 1'b0);
      resolve(64'h2000, 64'h3000, 1'b1);
      resolve(64'h2000, 64'h3000, 1'b1);
      look("hyst_strong", 64'h2000, 1'b1, 64'h3000, 1'b0);
      check_eq("cnt_sat", dut.cnt_r[0], 64'd3);

      resolve(64'h2000, 64'h4000, 1'b1);
      look("tgt_clear", 64'h2000, 1'b1, 64'h4000, 1'b1);
      look("tgt_pred", 64'h2000, 1'b1, 64'h4000, 1'b0);

      for (int i = 1; i < N; i++) resolve(64'h5000 + 64'(i) * 64'h10, 64'h7000 + 64'(i) * 64'h10, 1'b1);
      look("fill_last", 64'h5070, 1'b1, 64'h7070, 1'b1);

      resolve(64'h9000, 64'h9100, 1'b1);
      look("rr0_new", 64'h9000, 1'b1, 64'h9100, 1'b1);
      look("rr0_old", 64'h2000, 1'b0, 64'h2004, 1'b0);
      look("rr0_keep", 64'h5010, 1'b1, 64'h7010, 1'b0);
      resolve(64'h9010, 64'h9110, 1'b1);
      look("rr1_new", 64'h9010, 1'b1, 64'h9110, 1'b1);
      look("rr1_old", 64'h5010, 1'b0, 64'h5014, 1'b0);
      look("rr1_keep", 64'h5020, 1'b1, 64'h7020, 1'b0);
      resolve(64'h9020, 64'h9120, 1'b1);
      look("rr2_new", 64'h9020, 1'b1, 64'h9120, 1'b1);
      look("rr2_old", 64'h5020, 1'b0, 64'h5024, 1'b0);
      look("rr2_keep", 64'h5030, 1'b1, 64'h7030, 1'b0);

      // Mispredicting resolve, then reset lands before its clear can rise.
      pc_i = 64'h5030; curr_addr_i = 64'h5030; next_addr_i = '0; is_jump_i = 1'b0;
      resolve_valid_i = 1'b1;
      @(negedge clk);
      arst_ni = 1'b0;
      #1;
      check_eq("rst_hit", hit_o, 1'b0);
      check_eq("rst_next_pc", next_pc_o, 64'h5034);
      check_eq("rst_clear", pipeline_clear_o, 1'b0);
      @(posedge clk); #1;
      check_eq("rst_edge_clear", pipeline_clear_o, 1'b0);
      resolve_valid_i = 1'b0;
      @(negedge clk);
      arst_ni = 1'b1;
      model_reset();
      look("post_rst_a", 64'h9000, 1'b0, 64'h9004, 1'b0);
      look("post_rst_b", 64'h5070, 1'b0, 64'h5074, 1'b0);
      look("post_rst_c", 64'h5040, 1'b0, 64'h5044, 1'b0);

      repeat (3000) begin
         pc_i = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : rand_addr();
         resolve_valid_i = 1'($urandom_range(0, 1));
         curr_addr_i = rand_addr();
         next_addr_i = 64'h8000 + 64'($urandom_range(0, 3)) * 64'h10 + 64'($urandom_range(0, 3));
         is_jump_i = 1'($urandom_range(0, 1));
         cycle_chk(1'b0, "", 1'b0, '0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
